// File: rtl/hlayer_pp_scheduler_pkg.sv
// Shared definitions for the hidden-layer-1 potential-processing scheduler:
// default geometry, FSM state encoding and the potential_bus slice helper.
package hlayer_pp_scheduler_pkg;

  localparam int N_NEURON = 8;
  localparam int W_POT    = 32;
  localparam int T_TU     = 350;
  localparam int TW_TU    = 9;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_INIT       = 4'd1,
    ST_TU_START   = 4'd2,
    ST_WAIT_PP1   = 4'd3,
    ST_WAIT_PP2   = 4'd4,
    ST_WAIT_PP3M  = 4'd5,
    ST_ARGMAX     = 4'd6,
    ST_ISSUE_PP3M = 4'd7,
    ST_WAIT_PP3   = 4'd8,
    ST_TU_END     = 4'd9,
    ST_DONE       = 4'd10
  } pp_state_e;

  // LSB position of neuron idx inside a packed potential bus.
  function automatic int pot_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/hlayer_pp_scheduler_wta.sv
// Serial winner-take-all scan: N cycles starting with the cycle start is seen.
// done/idx are valid in the last scan cycle and already include its compare.
module wta_argmax_serial
  import hlayer_pp_scheduler_pkg::*;
#(
  parameter int N = N_NEURON,
  parameter int W = W_POT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*W-1:0]       potential_bus,
  output logic                 done,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic signed [W-1:0] pot_s [N];
  logic signed [W-1:0] best_r;
  logic [IW-1:0]       idx_r;
  logic [IW-1:0]       cnt_r;
  logic                active_r;
  logic                gt_s;

  // Unpack the potential bus into signed per-neuron values.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      pot_s[i] = potential_bus[pot_lsb(i, W) +: W];
    end
  end

  assign gt_s = active_r && (pot_s[cnt_r] > best_r);
  assign done = active_r && (cnt_r == IW'(N - 1));
  assign idx  = gt_s ? cnt_r : idx_r;

  // Scan state: load neuron 0, then strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_r   <= '0;
      idx_r    <= '0;
      cnt_r    <= '0;
      active_r <= 1'b0;
    end else if (start) begin
      best_r   <= pot_s[0];
      idx_r    <= '0;
      cnt_r    <= IW'(1);
      active_r <= 1'b1;
    end else if (active_r) begin
      if (gt_s) begin
        best_r <= pot_s[cnt_r];
        idx_r  <= cnt_r;
      end
      if (cnt_r == IW'(N - 1)) begin
        active_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r + IW'(1);
      end
    end else begin
      active_r <= 1'b0;
    end
  end

endmodule

// File: rtl/hlayer_pp_scheduler.sv
// Per-image / per-TU sequencer for the hidden-layer-1 neurons (pp1, pp2 or WTA+pp3 per TU).
// Optional macro PP_WATCHDOG_EN adds a WAIT-state watchdog driving the sticky err flag.
module hlayer_pp_scheduler
  import hlayer_pp_scheduler_pkg::*;
#(
  parameter int N  = N_NEURON,
  parameter int W  = W_POT,
  parameter int T  = T_TU,
  parameter int TW = TW_TU
`ifdef PP_WATCHDOG_EN
  , parameter int WD_CYC = 4096
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_img,
  input  logic                 learn,
  input  logic                 spike_ip_any,
  input  logic [N-1:0]         valid_pp1,
  input  logic [N-1:0]         valid_pp2,
  input  logic [N-1:0]         valid_pp3m,
  input  logic [N-1:0]         valid_pp3,
  input  logic [N*W-1:0]       potential_bus,
  output logic                 start_core_img,
  output logic                 start_pp1,
  output logic                 start_pp2,
  output logic                 start_pp3,
  output logic                 start_pp3m,
  output logic [N-1:0]         won_lost_hold,
  output logic                 TU_incre,
  output logic [TW-1:0]        tu_count,
  output logic [$clog2(N)-1:0] winner_idx,
  output logic                 busy,
  output logic                 img_done,
  output logic                 err
);

  localparam int IW = $clog2(N);

  pp_state_e     st_r;
  logic [N-1:0]  collect_r;
  logic [N-1:0]  valid_sel_s;
  logic [N-1:0]  collect_next_s;
  logic          in_wait_s;
  logic          wd_hit_s;
  logic          exit_s;
  logic          argmax_start_r;
  logic          wta_done_s;
  logic [IW-1:0] wta_idx_s;

  // Only the valid bus belonging to the current wait state is collected.
  always_comb begin
    valid_sel_s = '0;
    in_wait_s   = 1'b1;
    case (st_r)
      ST_WAIT_PP1:  valid_sel_s = valid_pp1;
      ST_WAIT_PP2:  valid_sel_s = valid_pp2;
      ST_WAIT_PP3M: valid_sel_s = valid_pp3m;
      ST_WAIT_PP3:  valid_sel_s = valid_pp3;
      default:      in_wait_s   = 1'b0;
    endcase
  end

  assign collect_next_s = collect_r | valid_sel_s;
  assign exit_s         = (&collect_next_s) | wd_hit_s;

`ifdef PP_WATCHDOG_EN
  localparam int WDW = $clog2(WD_CYC + 1);
  logic [WDW-1:0] wd_cnt_r;
  logic           err_r;

  assign wd_hit_s = in_wait_s && (wd_cnt_r == WDW'(WD_CYC - 1));
  assign err      = err_r;

  // Counter restarts whenever the FSM is outside a wait state; err is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r <= '0;
      err_r    <= 1'b0;
    end else begin
      if (in_wait_s) begin
        wd_cnt_r <= wd_cnt_r + WDW'(1);
      end else begin
        wd_cnt_r <= '0;
      end
      if (wd_hit_s) begin
        err_r <= 1'b1;
      end
    end
  end
`else
  assign wd_hit_s = 1'b0;
  assign err      = 1'b0;
`endif

  wta_argmax_serial #(.N(N), .W(W)) u_wta (
    .clk           (clk),
    .rst           (rst),
    .start         (argmax_start_r),
    .potential_bus (potential_bus),
    .done          (wta_done_s),
    .idx           (wta_idx_s)
  );

  // Main sequencer with registered pulse and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_r           <= ST_IDLE;
      collect_r      <= '0;
      argmax_start_r <= 1'b0;
      start_core_img <= 1'b0;
      start_pp1      <= 1'b0;
      start_pp2      <= 1'b0;
      start_pp3      <= 1'b0;
      start_pp3m     <= 1'b0;
      won_lost_hold  <= '0;
      TU_incre       <= 1'b0;
      tu_count       <= '0;
      winner_idx     <= '0;
      busy           <= 1'b0;
      img_done       <= 1'b0;
    end else begin
      start_core_img <= 1'b0;
      start_pp1      <= 1'b0;
      start_pp2      <= 1'b0;
      start_pp3      <= 1'b0;
      start_pp3m     <= 1'b0;
      TU_incre       <= 1'b0;
      img_done       <= 1'b0;
      argmax_start_r <= 1'b0;
      case (st_r)
        ST_IDLE: begin
          if (start_img) begin
            st_r <= ST_INIT;
            busy <= 1'b1;
          end
        end
        ST_INIT: begin
          start_core_img <= 1'b1;
          tu_count       <= '0;
          st_r           <= ST_TU_START;
        end
        ST_TU_START: begin
          collect_r <= '0;
          if (!spike_ip_any) begin
            start_pp1 <= 1'b1;
            st_r      <= ST_WAIT_PP1;
          end else if (!learn) begin
            start_pp2 <= 1'b1;
            st_r      <= ST_WAIT_PP2;
          end else begin
            start_pp3 <= 1'b1;
            st_r      <= ST_WAIT_PP3M;
          end
        end
        ST_WAIT_PP1, ST_WAIT_PP2, ST_WAIT_PP3M, ST_WAIT_PP3: begin
          collect_r <= wd_hit_s ? '1 : collect_next_s;
          if (exit_s) begin
            if (st_r == ST_WAIT_PP3M) begin
              argmax_start_r <= 1'b1;
              st_r           <= ST_ARGMAX;
            end else begin
              st_r <= ST_TU_END;
            end
          end
        end
        ST_ARGMAX: begin
          if (wta_done_s) begin
            winner_idx <= wta_idx_s;
            st_r       <= ST_ISSUE_PP3M;
          end
        end
        ST_ISSUE_PP3M: begin
          won_lost_hold <= {{(N-1){1'b0}}, 1'b1} << winner_idx;
          start_pp3m    <= 1'b1;
          collect_r     <= '0;
          st_r          <= ST_WAIT_PP3;
        end
        ST_TU_END: begin
          TU_incre      <= 1'b1;
          won_lost_hold <= '0;
          if (tu_count == TW'(T - 1)) begin
            st_r <= ST_DONE;
          end else begin
            tu_count <= tu_count + TW'(1);
            st_r     <= ST_TU_START;
          end
        end
        ST_DONE: begin
          img_done <= 1'b1;
          busy     <= 1'b0;
          st_r     <= ST_IDLE;
        end
        default: begin
          busy <= 1'b0;
          st_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
